pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Drives their enables and flushes.
//  Detects load-use hazards, taken-branch redirects and multi-cycle data-memory waits.
//  Sits beside the ID/EX register; consumes its EX-side outputs plus decode-stage fields.
//  Has a memory-wait watchdog with a sticky timeout error.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max consecutive MEM_WAIT cycles before entering HZ_ERROR (>=1)
//  PERF_W          32   width of performance counters (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk             in   1   clock; all state changes on posedge
//  rstN            in   1   asynchronous, active-low reset
//  rs1_ID          in   5   regName_t, source reg 1 of instruction in ID
//  rs2_ID          in   5   regName_t, source reg 2 of instruction in ID
//  usesRs1_ID      in   1   ID instruction reads rs1
//  usesRs2_ID      in   1   ID instruction reads rs2
//  memRead_EX      in   1   instruction in EX is a load (ID/EX memRead output)
//  rd_EX           in   5   regName_t, destination of instruction in EX
//  branchTaken_EX  in   1   EX resolved a taken branch/jump this cycle
//  dmemReq_MEM     in   1   MEM stage has an active data-memory access
//  dmemReady_MEM   in   1   data memory completes the access this cycle
//  pcEn            out  1   PC load enable
//  ifIdEn          out  1   IF/ID enable
//  ifIdFlush       out  1   IF/ID synchronous clear to NOP
//  idExEn          out  1   ID/EX enable
//  idExFlush       out  1   ID/EX synchronous clear (bubble: all control = 0)
//  exMemEn         out  1   EX/MEM enable
//  memWbBubble     out  1   MEM/WB loads a bubble (regWrite = 0)
//  memTimeout      out  1   sticky watchdog error, registered
//  stallCycles, flushCount, memWaitCycles  out  PERF_W  perf counters, present only with the macro
// BEHAVIOUR
//  State hzState_t: HZ_RUN, HZ_MEM_WAIT, HZ_ERROR. Reset -> HZ_RUN, waitCnt = 0, memTimeout = 0.
//  Enable/flush outputs are combinational from state and inputs; 0-cycle latency.
//  Reset values with inputs low: all enables = 1, all flushes/bubble = 0.
//  Priority is memory stall > branch flush > load-use stall.
//  Memory stall: dmemReq_MEM & ~dmemReady_MEM, in any state except HZ_ERROR, freezes the pipeline.
//   Freeze: pcEn = ifIdEn = idExEn = exMemEn = 0, memWbBubble = 1, flushes = 0.
//   The freeze applies in the same cycle. State -> HZ_MEM_WAIT, waitCnt increments.
//  HZ_MEM_WAIT + dmemReady_MEM: freeze released in that cycle, -> HZ_RUN, waitCnt = 0.
//  HZ_MEM_WAIT with waitCnt == TIMEOUT_CYCLES-1 and still not ready: -> HZ_ERROR.
//  HZ_ERROR: memTimeout = 1 from the next cycle, pipeline frozen permanently; only rstN exits.
//  Branch (no memory stall): ifIdFlush = 1, idExFlush = 1, pcEn = 1 (redirect), all enables = 1.
//  Load-use (no memory stall, no branch): memRead_EX & rd_EX != zero & ((usesRs1_ID & rs1_ID == rd_EX) | (usesRs2_ID & rs2_ID == rd_EX)).
//   Response: pcEn = 0, ifIdEn = 0, idExFlush = 1. Exactly 1 bubble per hazard.
//  Branch + load-use in the same cycle: branch wins; the wrong-path ID instruction is flushed, not stalled.
//  rd_EX == x0 never causes a stall.
//  waitCnt width is $clog2(TIMEOUT_CYCLES+1). waitCnt never wraps.
//  Reset asserted mid-wait aborts immediately to HZ_RUN with counters cleared.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds 3 saturating PERF_W counters, reset to 0.
//   stallCycles: load-use cycles. flushCount: branch flushes. memWaitCycles: frozen cycles.
//   Counters hold at all-ones and never wrap.
//  HAZARD_PERF_CNT_EN undefined: the counters and their ports do not exist; all other behaviour is identical.
// STRUCTURE
//  Package definitions gains hzState_t (enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_ERROR}).
//  Reuses the existing regName_t and its zero member.
//  Sub-module hazard_match (combinational): rs/rd compare producing loadUse.
//  The FSM, watchdog and perf counters stay in this module.
// TESTING
//  1. rstN low then high, all inputs 0 -> pcEn = ifIdEn = idExEn = exMemEn = 1, flushes 0, memTimeout 0.
//  2. memRead_EX = 1, rd_EX = 5, rs2_ID = 5, usesRs2_ID = 1 -> one cycle pcEn = 0, ifIdEn = 0, idExFlush = 1.
//     Same stimulus with rd_EX = 0 -> no stall.
//  3. Load-use as in 2 plus branchTaken_EX = 1 -> ifIdFlush = idExFlush = 1, pcEn = 1.
//     With HAZARD_PERF_CNT_EN: flushCount += 1, stallCycles unchanged.
//  4. dmemReq_MEM = 1, dmemReady_MEM low for 3 cycles then high -> freeze for exactly 3 cycles.
//     Released in the ready cycle, state HZ_RUN; with macro, memWaitCycles = 3.
//  5. TIMEOUT_CYCLES = 4, ready never asserted -> HZ_ERROR after 4 wait cycles, then memTimeout = 1.
//     Pipeline stays frozen; rstN pulse clears it.
//  6. rstN pulsed low during HZ_MEM_WAIT -> immediate HZ_RUN defaults, waitCnt = 0, all counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: architectural register names and FSM states.
// Exports regName_t (the zero member is x0) and hzState_t.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [4:0] {
    zero, ra, sp, gp, tp, t0, t1, t2, s0, s1, a0, a1, a2, a3, a4, a5,
    a6, a7, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, t3, t4, t5, t6
  } regName_t;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERROR    = 2'd2
  } hzState_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_match.sv
// Load-use detector: a load in EX targets a register read by the ID instruction.
// Purely combinational, 0-cycle latency; x0 destinations never match.
module hazard_match
  import pipeline_hazard_ctrl_pkg::*;
(
  input  regName_t rs1_ID,
  input  regName_t rs2_ID,
  input  logic     usesRs1_ID,
  input  logic     usesRs2_ID,
  input  logic     memRead_EX,
  input  regName_t rd_EX,
  output logic     loadUse
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = usesRs1_ID && (rs1_ID == rd_EX);
  assign rs2_hit = usesRs2_ID && (rs2_ID == rd_EX);
  assign loadUse = memRead_EX && (rd_EX != zero) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline register sequencer: mem freeze > branch flush > load-use stall, 0-cycle enables.
// Memory-wait watchdog with sticky memTimeout; HAZARD_PERF_CNT_EN adds saturating perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
`ifdef HAZARD_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic     clk,
  input  logic     rstN,
  input  regName_t rs1_ID,
  input  regName_t rs2_ID,
  input  logic     usesRs1_ID,
  input  logic     usesRs2_ID,
  input  logic     memRead_EX,
  input  regName_t rd_EX,
  input  logic     branchTaken_EX,
  input  logic     dmemReq_MEM,
  input  logic     dmemReady_MEM,
  output logic     pcEn,
  output logic     ifIdEn,
  output logic     ifIdFlush,
  output logic     idExEn,
  output logic     idExFlush,
  output logic     exMemEn,
  output logic     memWbBubble,
  output logic     memTimeout
`ifdef HAZARD_PERF_CNT_EN
  , output logic [PERF_W-1:0] stallCycles
  , output logic [PERF_W-1:0] flushCount
  , output logic [PERF_W-1:0] memWaitCycles
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  hzState_t        state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            load_use;
  logic            mem_stall;
  logic            frozen;
  logic            br_flush;
  logic            lu_stall;

  hazard_match u_match (
    .rs1_ID     (rs1_ID),
    .rs2_ID     (rs2_ID),
    .usesRs1_ID (usesRs1_ID),
    .usesRs2_ID (usesRs2_ID),
    .memRead_EX (memRead_EX),
    .rd_EX      (rd_EX),
    .loadUse    (load_use)
  );

  assign mem_stall = dmemReq_MEM && !dmemReady_MEM && (state_q != HZ_ERROR);
  assign frozen    = mem_stall || (state_q == HZ_ERROR);
  assign br_flush  = !frozen && branchTaken_EX;
  assign lu_stall  = !frozen && !branchTaken_EX && load_use;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pcEn        = 1'b1;
    ifIdEn      = 1'b1;
    ifIdFlush   = 1'b0;
    idExEn      = 1'b1;
    idExFlush   = 1'b0;
    exMemEn     = 1'b1;
    memWbBubble = 1'b0;

    // The watchdog trips on the TIMEOUT_CYCLES-th consecutive stalled cycle.
    if (state_q != HZ_ERROR) begin
      if (mem_stall) begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        state_d    = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) ? HZ_ERROR : HZ_MEM_WAIT;
      end else begin
        wait_cnt_d = '0;
        state_d    = HZ_RUN;
      end
    end

    if (frozen) begin
      pcEn        = 1'b0;
      ifIdEn      = 1'b0;
      idExEn      = 1'b0;
      exMemEn     = 1'b0;
      memWbBubble = 1'b1;
    end else if (br_flush) begin
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (lu_stall) begin
      pcEn      = 1'b0;
      ifIdEn    = 1'b0;
      idExFlush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= '0;
      memTimeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_d == HZ_ERROR) memTimeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stallCycles   <= '0;
      flushCount    <= '0;
      memWaitCycles <= '0;
    end else begin
      if (lu_stall && (stallCycles != '1))  stallCycles   <= stallCycles + PERF_W'(1);
      if (br_flush && (flushCount != '1))   flushCount    <= flushCount + PERF_W'(1);
      if (frozen && (memWaitCycles != '1))  memWaitCycles <= memWaitCycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + randomized bench for pipeline_hazard_ctrl against a rule-level reference model.
// Set HAZARD_PERF_CNT_EN to also check the perf counters.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int TO = 4;

  logic     clk = 1'b0;
  logic     rstN;
  regName_t rs1_ID, rs2_ID, rd_EX;
  logic     usesRs1_ID, usesRs2_ID, memRead_EX, branchTaken_EX, dmemReq_MEM, dmemReady_MEM;
  logic     pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbBubble, memTimeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCycles, flushCount, memWaitCycles;
`endif

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstN(rstN),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .usesRs1_ID(usesRs1_ID), .usesRs2_ID(usesRs2_ID),
    .memRead_EX(memRead_EX), .rd_EX(rd_EX), .branchTaken_EX(branchTaken_EX),
    .dmemReq_MEM(dmemReq_MEM), .dmemReady_MEM(dmemReady_MEM),
    .pcEn(pcEn), .ifIdEn(ifIdEn), .ifIdFlush(ifIdFlush), .idExEn(idExEn),
    .idExFlush(idExFlush), .exMemEn(exMemEn), .memWbBubble(memWbBubble), .memTimeout(memTimeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCycles(stallCycles), .flushCount(flushCount), .memWaitCycles(memWaitCycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: sticky error, consecutive stalled cycles, event tallies.
  bit m_err;
  int m_streak;
  int m_stall_cnt, m_flush_cnt, m_wait_cnt;

  // Output vector order: pcEn ifIdEn ifIdFlush idExEn idExFlush exMemEn memWbBubble memTimeout
  localparam logic [7:0] V_IDLE = 8'b1101_0100;
  localparam logic [7:0] V_LU   = 8'b0001_1100;
  localparam logic [7:0] V_BR   = 8'b1111_1100;
  localparam logic [7:0] V_FRZ  = 8'b0000_0010;

  function automatic logic [7:0] obs_vec();
    return {pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbBubble, memTimeout};
  endfunction

  function automatic bit m_load_use();
    int rd = int'(rd_EX);
    return memRead_EX && rd != 0 &&
           ((usesRs1_ID && int'(rs1_ID) == rd) || (usesRs2_ID && int'(rs2_ID) == rd));
  endfunction

  function automatic bit m_stalled();
    return dmemReq_MEM && !dmemReady_MEM && !m_err;
  endfunction

  function automatic logic [7:0] m_expect();
    logic [7:0] v;
    if (m_stalled() || m_err) v = V_FRZ;
    else if (branchTaken_EX)  v = V_BR;
    else if (m_load_use())    v = V_LU;
    else                      v = V_IDLE;
    v[0] = m_err;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall"}, stallCycles, m_stall_cnt);
    check({tag, "_flush"}, flushCount, m_flush_cnt);
    check({tag, "_wait"}, memWaitCycles, m_wait_cnt);
`else
    if (tag.len() == 0) $display("perf counters absent");
`endif
  endtask

  task automatic drive(input int r1, input int r2, input bit u1, input bit u2, input bit mr,
                       input int rd, input bit br, input bit req, input bit rdy);
    rs1_ID = regName_t'(r1[4:0]);  rs2_ID = regName_t'(r2[4:0]);  rd_EX = regName_t'(rd[4:0]);
    usesRs1_ID = u1;  usesRs2_ID = u2;  memRead_EX = mr;
    branchTaken_EX = br;  dmemReq_MEM = req;  dmemReady_MEM = rdy;
  endtask

  task automatic model_reset();
    m_err = 0;  m_streak = 0;  m_stall_cnt = 0;  m_flush_cnt = 0;  m_wait_cnt = 0;
  endtask

  // One clock cycle: compare combinational outputs to the model, then advance the model.
  task automatic step(input string tag, input bit use_k, input logic [7:0] k);
    bit stall, frozen, lu;
    @(negedge clk);
    check(tag, obs_vec(), m_expect());
    if (use_k) check({tag, "_k"}, obs_vec(), k);
    stall  = m_stalled();
    frozen = stall || m_err;
    lu     = m_load_use();
    if (frozen) m_wait_cnt++;
    else if (branchTaken_EX) m_flush_cnt++;
    else if (lu) m_stall_cnt++;
    if (stall) begin
      m_streak++;
      if (m_streak == TO) m_err = 1;
    end else if (!m_err) begin
      m_streak = 0;
    end
    @(posedge clk);
    #1;
    check_perf(tag);
  endtask

  task automatic do_reset(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstN = 1'b0;
    #2;
    model_reset();
    check(tag, obs_vec(), V_IDLE);
    check_perf(tag);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    rstN = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;

    // Reset defaults
    do_reset("reset");
    step("idle", 1, V_IDLE);

    // Load-use through rs2, then the bubble lets it go; x0 destination never stalls
    drive(0, 5, 0, 1, 1, 5, 0, 0, 0);  step("lu_rs2", 1, V_LU);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("lu_after", 1, V_IDLE);
    drive(0, 0, 0, 1, 1, 0, 0, 0, 0);  step("lu_x0", 1, V_IDLE);
    drive(7, 0, 1, 0, 1, 7, 0, 0, 0);  step("lu_rs1", 1, V_LU);
    drive(7, 0, 0, 0, 1, 7, 0, 0, 0);  step("lu_unused", 1, V_IDLE);

    // Branch beats load-use
    drive(0, 5, 0, 1, 1, 5, 1, 0, 0);  step("br_lu", 1, V_BR);

    // Three-cycle memory wait, released in the ready cycle
    for (int i = 0; i < 3; i++) begin
      drive(0, 5, 0, 1, 1, 5, 1, 1, 0);  step("mwait", 1, V_FRZ);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);  step("mrel", 1, V_IDLE);
    check("mwait_total", m_wait_cnt, 3);

    // Watchdog: TO stalled cycles, then sticky error with permanent freeze
    for (int i = 0; i < TO; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  step("wd_wait", 1, V_FRZ);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("wd_err", 1, V_FRZ | 8'h01);
    drive(1, 1, 1, 1, 1, 1, 1, 1, 1);  step("wd_hold", 1, V_FRZ | 8'h01);
    do_reset("wd_reset");
    step("wd_clear", 1, V_IDLE);

    // Reset mid-wait, then TO-1 stalls must not trip the watchdog
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("mid_a", 1, V_FRZ);
    step("mid_b", 1, V_FRZ);
    do_reset("mid_reset");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TO - 1; i++) step("mid_wait", 1, V_FRZ);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);  step("mid_rel", 1, V_IDLE);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      step("rand", 0, 8'h00);
      if (i == 200) do_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
